qrisc32_dmem_unit: RTL and testbench

Data-memory access stage of the Qrisc32 pipeline, sitting directly after the execute stage. It consumes the execute stage's registered `pipe_struct_t`, turns `read_mem`/`write_mem` operations into a request/acknowledge transaction on the data-memory bus, and stalls the upstream pipeline while the transaction is in flight. It forwards completed operations, with load data merged into `val_dst`, to write-back.

---
 rtl/risc_pack.sv | 28 ++
 rtl/qrisc32_dmem_unit_if.sv | 20 ++
 rtl/qrisc32_dmem_watchdog.sv | 43 ++++
 rtl/qrisc32_dmem_unit.sv | 137 +++++++++++++
 tb/tb_qrisc32_dmem_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pack.sv
// Shared Qrisc32 pipeline types: the inter-stage pipe record and the
// data-memory stage state encoding.
package risc_pack;

   localparam int unsigned DMEM_TIMEOUT_DEFAULT = 32'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] val_r1;
      logic [31:0] val_r2;
      logic [31:0] val_dst;
      logic [4:0]  dst_reg;
      logic        write_reg;
      logic        read_mem;
      logic        write_mem;
   } pipe_struct_t;

   function automatic logic is_mem_op(input pipe_struct_t p);
      return p.read_mem | p.write_mem;
   endfunction

endpackage

// File: rtl/qrisc32_dmem_unit_if.sv
// Data-memory request/acknowledge bus between the Qrisc32 memory stage
// (master) and the memory responder (slave).
interface qrisc32_dmem_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/qrisc32_dmem_watchdog.sv
// REQ-cycle counter for the data-memory stage; flags the last cycle allowed
// before an unacknowledged access is aborted. Built only with QRISC32_DMEM_TIMEOUT_EN.
`ifdef QRISC32_DMEM_TIMEOUT_EN
module qrisc32_dmem_watchdog #(
   parameter int unsigned LIMIT = 32'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam logic [15:0] LAST = 16'(LIMIT - 32'd1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Clear on entry to REQ, count each cycle still waiting for ack.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 16'd0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule
`endif

// File: rtl/qrisc32_dmem_unit.sv
// Qrisc32 data-memory stage: issues loads/stores on the dmem bus and stalls
// upstream while in flight. QRISC32_DMEM_TIMEOUT_EN enables the access watchdog.
module qrisc32_dmem_unit
   import risc_pack::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       areset,
   input  pipe_struct_t               pipe_mem_in,
   output logic                       pipe_stall,
   output pipe_struct_t               pipe_mem_out,
   qrisc32_dmem_unit_if.master        dmem_bus,
   output logic                       bus_err
);

   dmem_state_t  state_q, state_d;
   pipe_struct_t hold_q, hold_d;
   pipe_struct_t out_q, out_d;
   logic         req_q, req_d;
   logic         we_q, we_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic         err_q, err_d;
   logic         timeout_s;

`ifdef QRISC32_DMEM_TIMEOUT_EN
   logic start_s;
   logic wait_s;

   assign start_s = (state_q == IDLE) && is_mem_op(pipe_mem_in);
   assign wait_s  = (state_q == REQ) && !dmem_bus.dmem_ack;

   qrisc32_dmem_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (areset),
      .clr_i     (start_s),
      .inc_i     (wait_s),
      .expired_o (timeout_s)
   );
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state, bus and stall logic.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      out_d      = out_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      pipe_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mem_op(pipe_mem_in)) begin
               pipe_stall = 1'b1;
               hold_d     = pipe_mem_in;
               req_d      = 1'b1;
               we_d       = pipe_mem_in.write_mem;
               addr_d     = pipe_mem_in.val_r1;
               wdata_d    = pipe_mem_in.val_dst;
               out_d      = '0;
               state_d    = REQ;
            end else begin
               out_d = pipe_mem_in;
            end
         end
         REQ: begin
            pipe_stall = 1'b1;
            // Ack takes priority over a coincident timeout.
            if (dmem_bus.dmem_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) begin
                  hold_d.val_dst = dmem_bus.dmem_rdata;
               end else begin
                  hold_d = hold_q;
               end
            end else if (timeout_s) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
               if (!we_q) begin
                  hold_d.val_dst = 32'd0;
               end else begin
                  hold_d = hold_q;
               end
            end else begin
               state_d = REQ;
            end
         end
         DONE: begin
            out_d   = hold_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         out_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         out_q   <= out_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign pipe_mem_out        = out_q;
   assign dmem_bus.dmem_req   = req_q;
   assign dmem_bus.dmem_we    = we_q;
   assign dmem_bus.dmem_addr  = addr_q;
   assign dmem_bus.dmem_wdata = wdata_q;
   assign bus_err             = err_q;

endmodule

// File: tb/tb_qrisc32_dmem_unit.sv
// Self-checking bench for qrisc32_dmem_unit: scoreboard on pipe_mem_out plus
// per-scenario stall/bus checks. Timeout scenario runs with QRISC32_DMEM_TIMEOUT_EN.
module tb_qrisc32_dmem_unit;
   import risc_pack::*;

   logic         clk = 1'b0;
   logic         areset;
   pipe_struct_t pipe_mem_in;
   logic         pipe_stall;
   pipe_struct_t pipe_mem_out;
   logic         bus_err;

   int total = 0;
   int bad   = 0;

   pipe_struct_t exp_q[$];
   pipe_struct_t sb_exp;
   int n_stall, n_req, n_rise, n_busbad;

   qrisc32_dmem_unit_if dif();

   qrisc32_dmem_unit #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .areset       (areset),
      .pipe_mem_in  (pipe_mem_in),
      .pipe_stall   (pipe_stall),
      .pipe_mem_out (pipe_mem_out),
      .dmem_bus     (dif),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every non-bubble result must match the next expected op in order.
   always @(negedge clk) begin
      if (!areset && pipe_mem_out.pc != 32'd0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got pc=%h val_dst=%h, required no output", pipe_mem_out.pc, pipe_mem_out.val_dst);
         end else begin
            sb_exp = exp_q.pop_front();
            if (pipe_mem_out !== sb_exp) begin
               bad++;
               $display("FAIL sb_result: got %h, required %h", pipe_mem_out, sb_exp);
            end
         end
      end
   end

   // Present one op starting at cycle 0 and play the responder; ack in cycle k
   // unless give_ack is 0. Stray acks are driven in IDLE and DONE to prove they are ignored.
   task automatic mem_access(input pipe_struct_t op, input int k, input logic [31:0] rdata, input bit give_ack);
      pipe_struct_t e;
      bit           is_mem;
      bit           prev_req;
      int           last;
      is_mem = op.read_mem | op.write_mem;
      e = op;
      if (op.read_mem && !op.write_mem) e.val_dst = give_ack ? rdata : 32'd0;
      exp_q.push_back(e);
      n_stall = 0; n_req = 0; n_rise = 0; n_busbad = 0;
      prev_req = dif.dmem_req;
      last = is_mem ? k + 1 : 0;
      for (int c = 0; c <= last; c++) begin
         pipe_mem_in    = op;
         dif.dmem_ack   = (c == 0) || (c == k + 1) || (give_ack && is_mem && c == k);
         dif.dmem_rdata = (give_ack && c == k) ? rdata : 32'hDEAD_BEEF;
         @(negedge clk);
         if (pipe_stall) n_stall++;
         if (dif.dmem_req) begin
            n_req++;
            if (!prev_req) n_rise++;
            if (dif.dmem_we !== op.write_mem || dif.dmem_addr !== op.val_r1 ||
                dif.dmem_wdata !== op.val_dst) n_busbad++;
         end
         prev_req = dif.dmem_req;
         @(posedge clk); #1;
      end
      pipe_mem_in    = '0;
      dif.dmem_ack   = 1'b0;
      dif.dmem_rdata = 32'd0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total += 7;
      if (pipe_mem_out !== '0)      begin bad++; $display("FAIL rst_out: got %h, required 0", pipe_mem_out); end
      if (dif.dmem_req !== 1'b0)    begin bad++; $display("FAIL rst_req: got %b, required 0", dif.dmem_req); end
      if (dif.dmem_we !== 1'b0)     begin bad++; $display("FAIL rst_we: got %b, required 0", dif.dmem_we); end
      if (dif.dmem_addr !== 32'd0)  begin bad++; $display("FAIL rst_addr: got %h, required 0", dif.dmem_addr); end
      if (dif.dmem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h, required 0", dif.dmem_wdata); end
      if (bus_err !== 1'b0)         begin bad++; $display("FAIL rst_bus_err: got %b, required 0", bus_err); end
      if (pipe_stall !== 1'b0)      begin bad++; $display("FAIL rst_stall: got %b, required 0", pipe_stall); end
      @(posedge clk); #1;
      areset = 1'b0;
   endtask

   task automatic test_alu();
      pipe_struct_t op;
      op = '0; op.pc = 32'h1000; op.val_dst = 32'd5; op.dst_reg = 5'd3; op.write_reg = 1'b1;
      mem_access(op, 0, 32'd0, 1'b1);
      total++;
      if (n_stall !== 0) begin bad++; $display("FAIL alu_stall: got %0d stall cycles, required 0", n_stall); end
      op.pc = 32'h1004; op.val_dst = 32'd9; op.dst_reg = 5'd4;
      mem_access(op, 0, 32'd0, 1'b1);
      @(negedge clk);
      total += 2;
      if (pipe_mem_out.val_dst !== 32'd9) begin bad++; $display("FAIL alu_val: got %h, required 9", pipe_mem_out.val_dst); end
      if (pipe_stall !== 1'b0 || n_stall !== 0) begin bad++; $display("FAIL alu_stall2: got %0d/%b, required 0/0", n_stall, pipe_stall); end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      pipe_struct_t op;
      op = '0; op.pc = 32'h1008; op.val_r1 = 32'h100; op.read_mem = 1'b1; op.dst_reg = 5'd7; op.write_reg = 1'b1;
      mem_access(op, 1, 32'hCAFEF00D, 1'b1);
      total += 4;
      if (n_stall !== 2)  begin bad++; $display("FAIL rd_stall: got %0d, required 2", n_stall); end
      if (n_req !== 1)    begin bad++; $display("FAIL rd_req_cycles: got %0d, required 1", n_req); end
      if (n_rise !== 1)   begin bad++; $display("FAIL rd_req_pulses: got %0d, required 1", n_rise); end
      if (n_busbad !== 0) begin bad++; $display("FAIL rd_bus: got %0d bad bus cycles, required 0", n_busbad); end
      @(negedge clk);
      total += 2;
      if (pipe_mem_out.val_dst !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_data: got %h, required cafef00d", pipe_mem_out.val_dst); end
      if (pipe_mem_out.val_r1 !== 32'h100) begin bad++; $display("FAIL rd_addr_pass: got %h, required 100", pipe_mem_out.val_r1); end
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      pipe_struct_t op;
      op = '0; op.pc = 32'h100C; op.val_r1 = 32'h200; op.val_dst = 32'h12345678; op.write_mem = 1'b1;
      mem_access(op, 4, 32'h0, 1'b1);
      total += 4;
      if (n_stall !== 5)  begin bad++; $display("FAIL wr_stall: got %0d, required 5", n_stall); end
      if (n_req !== 4)    begin bad++; $display("FAIL wr_req_cycles: got %0d, required 4", n_req); end
      if (n_rise !== 1)   begin bad++; $display("FAIL wr_req_pulses: got %0d, required 1", n_rise); end
      if (n_busbad !== 0) begin bad++; $display("FAIL wr_bus: got %0d bad bus cycles, required 0", n_busbad); end
      @(negedge clk);
      total++;
      if (pipe_mem_out.val_dst !== 32'h12345678) begin bad++; $display("FAIL wr_pass: got %h, required 12345678", pipe_mem_out.val_dst); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      pipe_struct_t op;
      int r1, q1;
      op = '0; op.pc = 32'h1010; op.val_r1 = 32'h300; op.read_mem = 1'b1; op.dst_reg = 5'd1;
      mem_access(op, 2, 32'h11111111, 1'b1);
      r1 = n_rise; q1 = n_req;
      op.pc = 32'h1014; op.val_r1 = 32'h304; op.dst_reg = 5'd2;
      mem_access(op, 1, 32'h22222222, 1'b1);
      total += 4;
      if (r1 !== 1 || q1 !== 2)         begin bad++; $display("FAIL b2b_first_req: got %0d pulses/%0d cycles, required 1/2", r1, q1); end
      if (n_rise !== 1 || n_req !== 1)  begin bad++; $display("FAIL b2b_second_req: got %0d pulses/%0d cycles, required 1/1", n_rise, n_req); end
      if (n_busbad !== 0)               begin bad++; $display("FAIL b2b_bus: got %0d, required 0", n_busbad); end
      if (n_stall !== 2)                begin bad++; $display("FAIL b2b_stall: got %0d, required 2", n_stall); end
      @(negedge clk);
      total++;
      if (pipe_mem_out.val_dst !== 32'h22222222) begin bad++; $display("FAIL b2b_data: got %h, required 22222222", pipe_mem_out.val_dst); end
      @(posedge clk); #1;
   endtask

   task automatic test_both_flags();
      pipe_struct_t op;
      op = '0; op.pc = 32'h1018; op.val_r1 = 32'h400; op.val_dst = 32'hA5A5A5A5; op.read_mem = 1'b1; op.write_mem = 1'b1;
      mem_access(op, 2, 32'h0BADF00D, 1'b1);
      total++;
      if (n_busbad !== 0 || n_req !== 2) begin bad++; $display("FAIL both_we: got %0d bad/%0d req cycles, required 0/2", n_busbad, n_req); end
      @(negedge clk);
      total++;
      if (pipe_mem_out.val_dst !== 32'hA5A5A5A5) begin bad++; $display("FAIL both_data: got %h, required a5a5a5a5", pipe_mem_out.val_dst); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      pipe_struct_t op;
      op = '0; op.pc = 32'h101C; op.val_r1 = 32'h500; op.read_mem = 1'b1;
      pipe_mem_in = op; dif.dmem_ack = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (dif.dmem_req !== 1'b1) begin bad++; $display("FAIL mid_req_before: got %b, required 1", dif.dmem_req); end
      #1 areset = 1'b1;
      #1;
      total += 4;
      if (dif.dmem_req !== 1'b0)   begin bad++; $display("FAIL mid_req_drop: got %b, required 0", dif.dmem_req); end
      if (pipe_mem_out !== '0)     begin bad++; $display("FAIL mid_out: got %h, required 0", pipe_mem_out); end
      if (dut.state_q !== IDLE)    begin bad++; $display("FAIL mid_state: got %0d, required IDLE", dut.state_q); end
      if (dif.dmem_addr !== 32'd0) begin bad++; $display("FAIL mid_addr: got %h, required 0", dif.dmem_addr); end
      pipe_mem_in = '0;
      @(posedge clk); #1;
      areset = 1'b0;
   endtask

   task automatic test_after_reset();
      pipe_struct_t op;
      op = '0; op.pc = 32'h1020; op.val_dst = 32'd7; op.write_reg = 1'b1;
      mem_access(op, 0, 32'd0, 1'b1);
      @(negedge clk);
      total += 2;
      if (n_stall !== 0) begin bad++; $display("FAIL post_rst_stall: got %0d, required 0", n_stall); end
      if (pipe_mem_out.val_dst !== 32'd7) begin bad++; $display("FAIL post_rst_val: got %h, required 7", pipe_mem_out.val_dst); end
      @(posedge clk); #1;
   endtask

`ifdef QRISC32_DMEM_TIMEOUT_EN
   task automatic test_timeout();
      pipe_struct_t op;
      op = '0; op.pc = 32'h1024; op.val_r1 = 32'h600; op.val_dst = 32'h55; op.read_mem = 1'b1;
      mem_access(op, 8, 32'h0, 1'b0);
      total += 3;
      if (n_req !== 8)   begin bad++; $display("FAIL to_req_cycles: got %0d, required 8", n_req); end
      if (n_rise !== 1)  begin bad++; $display("FAIL to_req_pulses: got %0d, required 1", n_rise); end
      if (n_stall !== 9) begin bad++; $display("FAIL to_stall: got %0d, required 9", n_stall); end
      @(negedge clk);
      total += 2;
      if (pipe_mem_out.val_dst !== 32'd0) begin bad++; $display("FAIL to_data: got %h, required 0", pipe_mem_out.val_dst); end
      if (bus_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b, required 1", bus_err); end
      @(posedge clk); #1;
      op = '0; op.pc = 32'h1028; op.val_r1 = 32'h604; op.read_mem = 1'b1;
      mem_access(op, 1, 32'h77, 1'b1);
      @(negedge clk);
      total += 2;
      if (bus_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b, required 1", bus_err); end
      if (pipe_mem_out.val_dst !== 32'h77) begin bad++; $display("FAIL to_recover: got %h, required 77", pipe_mem_out.val_dst); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      areset         = 1'b1;
      pipe_mem_in    = '0;
      dif.dmem_ack   = 1'b0;
      dif.dmem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_alu();
      test_read();
      test_write();
      test_back_to_back();
      test_both_flags();
      test_reset_mid();
      test_after_reset();
`ifdef QRISC32_DMEM_TIMEOUT_EN
      test_timeout();
`else
      total++;
      if (bus_err !== 1'b0) begin bad++; $display("FAIL err_tied: got %b, required 0", bus_err); end
`endif
      repeat (2) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
